// File: rtl/sa_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : sa_buf_pkg                                                      |
// | Purpose  : Shared defaults, widths and helpers for the pipe buffer slice   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package sa_buf_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LANES_DEF = 4;
  localparam int DEPTH_DEF = 4;

  // Bus widths for the default configuration.
  localparam int DATA_W  = LANES_DEF * WIDTH_DEF;
  localparam int ENTRY_W = DATA_W + LANES_DEF;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Pointer width, never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_blkbox_pipe_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: sa_blkbox_pipe_buffer_if                                        |
// | Purpose  : Valid/ready word stream carrying LANES-wide data plus lane mask |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface sa_blkbox_pipe_buffer_if #(
  parameter int DATA_W = sa_buf_pkg::DATA_W,
  parameter int LANES  = sa_buf_pkg::LANES_DEF
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [LANES-1:0]  mask;

  // Producer side of the stream.
  modport master (
    output valid,
    output data,
    output mask,
    input  ready
  );

  // Consumer side of the stream.
  modport slave (
    input  valid,
    input  data,
    input  mask,
    output ready
  );

endinterface
`default_nettype wire

// File: rtl/sa_buf_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sa_buf_regfile                                                  |
// | Purpose  : DEPTH x ENTRY_W flop array, 1 sync write port, 1 async read     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sa_buf_regfile
  import sa_buf_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ENTRY_W = sa_buf_pkg::ENTRY_W,
  parameter int AW      = ptr_w(DEPTH)
) (
  input  wire logic               clk_i,
  input  wire logic               we_i,
  input  wire logic [AW-1:0]      waddr_i,
  input  wire logic [ENTRY_W-1:0] wdata_i,
  input  wire logic [AW-1:0]      raddr_i,
  output logic      [ENTRY_W-1:0] rdata_o
);

  // Storage is deliberately left unreset; readers mask it until written.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sa_blkbox_pipe_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sa_blkbox_pipe_buffer                                           |
// | Purpose  : Multi-lane elastic FIFO buffer with lane mask, flush and count  |
// |            between systolic PE rows and I/O modules                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sa_blkbox_pipe_buffer
  import sa_buf_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int LANES = LANES_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             flush_i,
  sa_blkbox_pipe_buffer_if.slave  in_s,
  sa_blkbox_pipe_buffer_if.master out_m,
  output logic      [CNT_W-1:0] count_o
);

  localparam int C_DW = LANES * WIDTH;
  localparam int C_EW = C_DW + LANES;
  localparam int C_PW = ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);
  localparam logic [C_PW-1:0]  C_LAST_PTR = C_PW'(DEPTH - 1);

  logic [C_PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [C_PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_wr_en;
  logic [C_EW-1:0]  w_wr_entry;
  logic [C_EW-1:0]  w_rd_entry;
  logic [C_DW-1:0]  w_head_data;
  logic [LANES-1:0] w_head_mask;
  logic [LANES-1:0] w_out_mask;
  logic [C_DW-1:0]  w_out_data;

  // Wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [C_PW-1:0] f_inc_ptr(input logic [C_PW-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake status comes only from the registered count, so in_ready
  // has no combinational dependency on out_ready.
  assign w_in_ready  = (count_q != C_FULL_CNT);
  assign w_out_valid = (count_q != '0);
  assign w_push      = in_s.valid & w_in_ready;
  assign w_pop       = w_out_valid & out_m.ready;

  // A flushed cycle drops the offered word.
  assign w_wr_en    = w_push & ~flush_i;
  assign w_wr_entry = {in_s.mask, in_s.data};

  // Next-state for pointers and occupancy; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        wr_ptr_d = f_inc_ptr(wr_ptr_q);
      end
      if (w_pop) begin
        rd_ptr_d = f_inc_ptr(rd_ptr_q);
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  sa_buf_regfile #(
    .DEPTH   (DEPTH),
    .ENTRY_W (C_EW),
    .AW      (C_PW)
  ) u_regfile (
    .clk_i   (clk_i),
    .we_i    (w_wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (w_wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_rd_entry)
  );

  assign w_head_data = w_rd_entry[C_DW-1:0];
  assign w_head_mask = w_rd_entry[C_EW-1:C_DW];

  // Gating by out_valid keeps never-written storage off the bus.
  assign w_out_mask = w_out_valid ? w_head_mask : '0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_out_data[g*WIDTH +: WIDTH] =
      w_out_mask[g] ? w_head_data[g*WIDTH +: WIDTH] : '0;
  end

  assign in_s.ready  = w_in_ready;
  assign out_m.valid = w_out_valid;
  assign out_m.data  = w_out_data;
  assign out_m.mask  = w_out_mask;
  assign count_o     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_sa_blkbox_pipe_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sa_blkbox_pipe_buffer                                        |
// | Purpose  : Scoreboard bench driving a DEPTH=4 and a DEPTH=3 buffer in      |
// |            parallel from shared directed and random stimulus              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sa_blkbox_pipe_buffer;

  localparam int W  = 32;
  localparam int L  = 4;
  localparam int DW = W * L;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [L-1:0]  mask;
  } exp_t;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic [L-1:0]  in_mask   = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sa_blkbox_pipe_buffer_if #(.DATA_W(DW), .LANES(L)) in4 ();
  sa_blkbox_pipe_buffer_if #(.DATA_W(DW), .LANES(L)) out4 ();
  sa_blkbox_pipe_buffer_if #(.DATA_W(DW), .LANES(L)) in3 ();
  sa_blkbox_pipe_buffer_if #(.DATA_W(DW), .LANES(L)) out3 ();

  assign in4.valid  = in_valid;
  assign in4.data   = in_data;
  assign in4.mask   = in_mask;
  assign out4.ready = out_ready;
  assign in3.valid  = in_valid;
  assign in3.data   = in_data;
  assign in3.mask   = in_mask;
  assign out3.ready = out_ready;

  logic [2:0] cnt4;
  logic [1:0] cnt3;

  sa_blkbox_pipe_buffer #(.WIDTH(W), .LANES(L), .DEPTH(4)) u_dut4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .in_s    (in4),
    .out_m   (out4),
    .count_o (cnt4)
  );

  sa_blkbox_pipe_buffer #(.WIDTH(W), .LANES(L), .DEPTH(3)) u_dut3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .in_s    (in3),
    .out_m   (out3),
    .count_o (cnt3)
  );

  // DUT observations gathered into arrays indexed 0 (DEPTH=4) / 1 (DEPTH=3).
  logic          o_valid [2];
  logic          i_ready [2];
  logic [DW-1:0] o_data  [2];
  logic [L-1:0]  o_mask  [2];
  int            o_cnt   [2];

  always_comb begin
    o_valid[0] = out4.valid;
    o_valid[1] = out3.valid;
    i_ready[0] = in4.ready;
    i_ready[1] = in3.ready;
    o_data[0]  = out4.data;
    o_data[1]  = out3.data;
    o_mask[0]  = out4.mask;
    o_mask[1]  = out3.mask;
    o_cnt[0]   = int'(cnt4);
    o_cnt[1]   = int'(cnt3);
  end

  // Reference model state: expected words in order, and occupancy.
  exp_t sbq  [2][$];
  int   mcnt [2];

  function automatic int dep(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic logic [DW-1:0] apply_mask(input logic [DW-1:0] d, input logic [L-1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < L; i++) begin
      if (m[i]) r[i*W +: W] = d[i*W +: W];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Model: accept into the expected queue when the producer is admitted.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        sbq[k].delete();
        mcnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit   acc;
        bit   pl;
        exp_t e;
        acc = in_valid && (mcnt[k] != dep(k));
        pl  = out_ready && (mcnt[k] != 0);
        if (flush) begin
          sbq[k].delete();
          mcnt[k] = 0;
        end else begin
          if (acc) begin
            e.data = apply_mask(in_data, in_mask);
            e.mask = in_mask;
            sbq[k].push_back(e);
          end
          mcnt[k] = mcnt[k] + int'(acc) - int'(pl);
        end
      end
    end
  end

  // Monitor: compare status every cycle, pop and compare the head word.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("in_ready",  k, DW'(i_ready[k]), DW'(mcnt[k] != dep(k)));
        chk("out_valid", k, DW'(o_valid[k]), DW'(mcnt[k] != 0));
        chk("count",     k, DW'(o_cnt[k]),   DW'(mcnt[k]));
        if (mcnt[k] != 0) begin
          if (sbq[k].size() == 0) begin
            chk("sb_underflow", k, DW'(0), DW'(1));
          end else begin
            chk("out_data", k, o_data[k],      sbq[k][0].data);
            chk("out_mask", k, DW'(o_mask[k]), DW'(sbq[k][0].mask));
            if (out_ready) void'(sbq[k].pop_front());
          end
        end else begin
          chk("idle_data", k, o_data[k],      '0);
          chk("idle_mask", k, DW'(o_mask[k]), '0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + i);
      in_mask  = 4'hF;
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 0, DW'(out4.valid), '0);
    chk("rst_in_ready",  0, DW'(in4.ready),  DW'(1));
    chk("rst_count",     0, DW'(cnt4),       '0);
    chk("rst_out_data",  0, out4.data,       '0);
    chk("rst_out_mask",  0, DW'(out4.mask),  '0);
    step();

    // Fill to full, then drain in order.
    out_ready = 1'b0;
    push_words(4, 1);
    chk("full_count",    0, DW'(cnt4),      DW'(4));
    chk("full_in_ready", 0, DW'(in4.ready), '0);
    out_ready = 1'b1;
    repeat (6) step();

    // Streaming with both sides always ready.
    out_ready = 1'b1;
    push_words(16, 32'h100);
    repeat (6) step();

    // Lane masking.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {4{32'hAAAA_AAAA}};
    in_mask   = 4'b0101;
    step();
    in_valid  = 1'b0;
    chk("mask_data", 0, out4.data,      {32'h0, 32'hAAAA_AAAA, 32'h0, 32'hAAAA_AAAA});
    chk("mask_mask", 0, DW'(out4.mask), DW'(4'b0101));
    out_ready = 1'b1;
    repeat (2) step();

    // Flush at count=3 together with push and pop.
    out_ready = 1'b0;
    push_words(3, 32'h11);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = DW'(32'hDEAD);
    in_mask   = 4'hF;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    chk("flush_count", 0, DW'(cnt4),       '0);
    chk("flush_valid", 0, DW'(out4.valid), '0);
    push_words(1, 32'h55);
    chk("post_flush_head", 0, out4.data, DW'(32'h55));
    repeat (2) step();

    // Asynchronous reset mid-cycle at count=3.
    out_ready = 1'b0;
    push_words(3, 32'h77);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 0, DW'(out4.valid), '0);
    chk("arst_in_ready",  0, DW'(in4.ready),  DW'(1));
    chk("arst_out_data",  0, out4.data,       '0);
    step();
    rst = 1'b0;
    chk("arst_count", 0, DW'(cnt4), '0);
    step();

    // Random traffic with occasional flush.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_mask   = 4'($urandom_range(0, 15));
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
